// File: rtl/game_pkg.sv
// Shared game-flow types for the space invaders top level: sequencer state
// encoding, end-screen status codes, the end/title mapper select and a
// saturating score adder.
package game_pkg;

    typedef enum logic [2:0] {
        StTitle,
        StLoad,
        StPlay,
        StCleared,
        StRetry,
        StWon,
        StLost
    } state_e;

    // end_status codes, meaningful while the end/title mapper is selected
    localparam logic [1:0] END_TITLE = 2'd0;
    localparam logic [1:0] END_HOLD  = 2'd1;
    localparam logic [1:0] END_WON   = 2'd2;
    localparam logic [1:0] END_LOST  = 2'd3;

    localparam logic [1:0] MAPPER_END = 2'd3;

    // 9-bit sum so the carry is seen before clamping
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] max_val);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[7:0];
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Bundle between the level sequencer and its surroundings: frame tick source,
// fire request, per-level win/loss/score reports and the outputs toward the
// VGA mux and score display. master = sequencer, slave = environment.
interface level_sequencer_if;

    logic       frame_clk;
    logic       shoot;
    logic       is_won;
    logic       is_lost;
    logic [7:0] score;
    logic [1:0] level;
    logic [1:0] color_mapper_select;
    logic       level_reset;
    logic [1:0] end_status;
    logic [7:0] display_score;
    logic [1:0] lives_left;

    modport master (
        input  frame_clk, shoot, is_won, is_lost, score,
        output level, color_mapper_select, level_reset, end_status, display_score, lives_left
    );

    modport slave (
        output frame_clk, shoot, is_won, is_lost, score,
        input  level, color_mapper_select, level_reset, end_status, display_score, lives_left
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick generator: brings VGA_VS into the Clk domain through a 2-flop
// synchroniser and emits a single-cycle pulse on each rising edge.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic i_async,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchroniser chain plus one delay stage for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: title, level load, play, inter-level hold, retry,
// game over and victory. Drives level select, mapper select and level reset,
// and banks the cumulative score.
// Optional feature macro: LEVEL_SEQ_LIVES_EN (lives counter and RETRY state).
module level_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned SCORE_MAX   = 99
) (
    input  logic              Clk,
    input  logic              Reset,
    level_sequencer_if.master bus
);

    localparam int unsigned      HoldW     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_FRAMES - 1);
    localparam logic [1:0]       LastLevel = 2'(NUM_LEVELS - 1);
    localparam logic [7:0]       ScoreMax  = 8'(SCORE_MAX);
    localparam logic [1:0]       LivesInit = 2'(LIVES);

    state_e           r_state, w_state_d;
    logic [1:0]       r_level, w_level_d;
    logic [7:0]       r_banked, w_banked_d;
    logic [HoldW-1:0] r_hold, w_hold_d;
    logic             r_shoot_q;
    logic             r_first_play;
    logic [1:0]       r_select, w_select_d;
    logic             r_level_reset, w_level_reset_d;
    logic [1:0]       r_end_status, w_end_status_d;
    logic [7:0]       r_display, w_display_d;
`ifdef LEVEL_SEQ_LIVES_EN
    logic [1:0]       r_lives, w_lives_d;
`endif

    logic w_tick;
    logic w_shoot_rise;

    frame_tick_gen u_frame_tick_gen (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_async (bus.frame_clk),
        .o_tick  (w_tick)
    );

    assign w_shoot_rise = bus.shoot & ~r_shoot_q;

    // State, game registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= StTitle;
            r_level       <= 2'd0;
            r_banked      <= 8'd0;
            r_hold        <= '0;
            r_shoot_q     <= 1'b0;
            r_first_play  <= 1'b0;
            r_select      <= MAPPER_END;
            r_level_reset <= 1'b1;
            r_end_status  <= END_TITLE;
            r_display     <= 8'd0;
`ifdef LEVEL_SEQ_LIVES_EN
            r_lives       <= LivesInit;
`endif
        end else begin
            r_state       <= w_state_d;
            r_level       <= w_level_d;
            r_banked      <= w_banked_d;
            r_hold        <= w_hold_d;
            r_shoot_q     <= bus.shoot;
            // Level flags are stale right after LOAD; mask them for one cycle
            r_first_play  <= (r_state == StLoad);
            r_select      <= w_select_d;
            r_level_reset <= w_level_reset_d;
            r_end_status  <= w_end_status_d;
            r_display     <= w_display_d;
`ifdef LEVEL_SEQ_LIVES_EN
            r_lives       <= w_lives_d;
`endif
        end
    end

    // Next-state and game-register updates
    always_comb begin
        w_state_d  = r_state;
        w_level_d  = r_level;
        w_banked_d = r_banked;
        w_hold_d   = r_hold;
`ifdef LEVEL_SEQ_LIVES_EN
        w_lives_d  = r_lives;
`endif
        unique case (r_state)
            StTitle: begin
                if (w_shoot_rise) begin
                    w_state_d  = StLoad;
                    w_level_d  = 2'd0;
                    w_banked_d = 8'd0;
`ifdef LEVEL_SEQ_LIVES_EN
                    w_lives_d  = LivesInit;
`endif
                end
            end
            StLoad: begin
                w_state_d = StPlay;
                w_hold_d  = '0;
            end
            StPlay: begin
                if (!r_first_play) begin
                    // Loss wins over a simultaneous win
                    if (bus.is_lost) begin
`ifdef LEVEL_SEQ_LIVES_EN
                        if (r_lives > 2'd1) begin
                            w_lives_d = r_lives - 2'd1;
                            w_state_d = StRetry;
                        end else begin
                            w_state_d = StLost;
                        end
`else
                        w_state_d = StLost;
`endif
                    end else if (bus.is_won) begin
                        w_banked_d = sat_add(r_banked, bus.score, ScoreMax);
                        w_state_d  = (r_level == LastLevel) ? StWon : StCleared;
                    end
                end
            end
            StCleared, StRetry: begin
                if (w_tick) begin
                    if (r_hold == HoldLast) begin
                        w_hold_d  = '0;
                        w_state_d = StLoad;
                        if (r_state == StCleared) begin
                            w_level_d = r_level + 2'd1;
                        end
                    end else begin
                        w_hold_d = r_hold + HoldW'(1);
                    end
                end
            end
            StWon, StLost: begin
                if (w_shoot_rise) begin
                    w_state_d = StTitle;
                end
            end
            default: w_state_d = StTitle;
        endcase
    end

    // Output values for the state being entered, registered above
    always_comb begin
        w_select_d      = (w_state_d == StPlay) ? w_level_d : MAPPER_END;
        w_level_reset_d = (w_state_d != StPlay);
        w_display_d     = (w_state_d == StPlay) ? sat_add(w_banked_d, bus.score, ScoreMax)
                                                : w_banked_d;
        case (w_state_d)
            StCleared, StRetry: w_end_status_d = END_HOLD;
            StWon:              w_end_status_d = END_WON;
            StLost:             w_end_status_d = END_LOST;
            default:            w_end_status_d = END_TITLE;
        endcase
    end

    assign bus.level               = r_level;
    assign bus.color_mapper_select = r_select;
    assign bus.level_reset         = r_level_reset;
    assign bus.end_status          = r_end_status;
    assign bus.display_score       = r_display;
`ifdef LEVEL_SEQ_LIVES_EN
    assign bus.lives_left          = r_lives;
`else
    assign bus.lives_left          = LivesInit;
`endif

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: a per-cycle vector table from reset,
// hand-written game sequences for the corner cases, then randomized games,
// all checked against a game-rule model kept in this file.
module tb_level_sequencer;

    localparam int NumLevels = 3;
    localparam int Hold      = 120;
    localparam int Lives     = 3;
    localparam int ScoreMax  = 99;

`ifdef LEVEL_SEQ_LIVES_EN
    localparam bit LivesEn = 1'b1;
`else
    localparam bit LivesEn = 1'b0;
`endif

    localparam int PhTitle   = 0;
    localparam int PhPlay    = 1;
    localparam int PhCleared = 2;
    localparam int PhRetry   = 3;
    localparam int PhWon     = 4;
    localparam int PhLost    = 5;

    logic clk;
    logic rst;
    level_sequencer_if bus ();

    level_sequencer #(
        .NUM_LEVELS  (NumLevels),
        .HOLD_FRAMES (Hold),
        .LIVES       (Lives),
        .SCORE_MAX   (ScoreMax)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Game-rule model
    int m_phase;
    int m_level;
    int m_banked;
    int m_lives;
    int m_score;

    typedef struct {
        logic       sh;
        logic       w;
        logic       l;
        logic [7:0] sc;
        logic [1:0] sel;
        logic       lr;
        logic [1:0] st;
        logic       st_chk;
        logic [7:0] disp;
    } vec_t;

    vec_t vecs[8];

    function automatic int sat(input int v);
        return (v > ScoreMax) ? ScoreMax : v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_st;
        case (m_phase)
            PhCleared, PhRetry: exp_st = 1;
            PhWon:              exp_st = 2;
            PhLost:             exp_st = 3;
            default:            exp_st = 0;
        endcase
        chk({tag, ".level"}, int'(bus.level), m_level);
        chk({tag, ".select"}, int'(bus.color_mapper_select), (m_phase == PhPlay) ? m_level : 3);
        chk({tag, ".level_reset"}, int'(bus.level_reset), (m_phase == PhPlay) ? 0 : 1);
        chk({tag, ".display"}, int'(bus.display_score),
            (m_phase == PhPlay) ? sat(m_banked + m_score) : m_banked);
        chk({tag, ".lives"}, int'(bus.lives_left), m_lives);
        if (m_phase != PhPlay) chk({tag, ".status"}, int'(bus.end_status), exp_st);
    endtask

    task automatic model_reset();
        m_phase  = PhTitle;
        m_level  = 0;
        m_banked = 0;
        m_lives  = Lives;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    // Title -> LOAD -> PLAY
    task automatic press();
        bus.shoot = 1'b1;
        step();
        chk("press_load.level_reset", int'(bus.level_reset), 1);
        chk("press_load.select", int'(bus.color_mapper_select), 3);
        bus.shoot = 1'b0;
        step();
        m_phase  = PhPlay;
        m_level  = 0;
        m_banked = 0;
        m_lives  = Lives;
        check_all("press_play");
    endtask

    // WON/LOST -> TITLE
    task automatic press_end();
        bus.shoot = 1'b1;
        step();
        bus.shoot = 1'b0;
        m_phase = PhTitle;
        check_all("press_end");
        step();
    endtask

    task automatic play_score(input int s);
        bus.score = 8'(s);
        m_score   = s;
        step();
        check_all("play");
    endtask

    task automatic outcome(input bit w, input bit l);
        bus.is_won  = w;
        bus.is_lost = l;
        step();
        bus.is_won  = 1'b0;
        bus.is_lost = 1'b0;
        if (l) begin
            if (LivesEn && m_lives > 1) begin
                m_lives--;
                m_phase = PhRetry;
            end else begin
                m_phase = PhLost;
            end
        end else if (w) begin
            m_banked = sat(m_banked + m_score);
            m_phase  = (m_level == NumLevels - 1) ? PhWon : PhCleared;
        end
        check_all("outcome");
    endtask

    task automatic do_hold();
        for (int p = 1; p <= Hold; p++) begin
            bus.frame_clk = 1'b1;
            step();
            step();
            bus.frame_clk = 1'b0;
            step();
            if (p == Hold) begin
                chk("hold_load.level_reset", int'(bus.level_reset), 1);
                chk("hold_load.select", int'(bus.color_mapper_select), 3);
            end
            step();
            if (p == Hold - 1) check_all("hold_wait");
        end
        if (m_phase == PhCleared) m_level++;
        m_phase = PhPlay;
        check_all("hold_play");
    endtask

    initial begin
        rst           = 1'b1;
        bus.frame_clk = 1'b0;
        bus.shoot     = 1'b0;
        bus.is_won    = 1'b0;
        bus.is_lost   = 1'b0;
        bus.score     = 8'd0;
        m_score       = 0;
        step();
        step();
        rst = 1'b0;
        model_reset();
        check_all("reset");

        // Per-cycle table: press, masked first PLAY flag, win, ignored inputs in hold
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 2'd0, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 2'd0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd12, 2'd0, 1'b0, 2'd0, 1'b0, 8'd12};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'd12, 2'd0, 1'b0, 2'd0, 1'b0, 8'd12};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd5,  2'd0, 1'b0, 2'd0, 1'b0, 8'd5};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd12, 2'd3, 1'b1, 2'd1, 1'b1, 8'd12};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'd12, 2'd3, 1'b1, 2'd1, 1'b1, 8'd12};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'd12, 2'd3, 1'b1, 2'd1, 1'b1, 8'd12};
        for (int i = 0; i < 8; i++) begin
            bus.shoot   = vecs[i].sh;
            bus.is_won  = vecs[i].w;
            bus.is_lost = vecs[i].l;
            bus.score   = vecs[i].sc;
            step();
            chk($sformatf("vec%0d.select", i), int'(bus.color_mapper_select),
                int'(vecs[i].sel));
            chk($sformatf("vec%0d.level_reset", i), int'(bus.level_reset), int'(vecs[i].lr));
            chk($sformatf("vec%0d.display", i), int'(bus.display_score), int'(vecs[i].disp));
            if (vecs[i].st_chk)
                chk($sformatf("vec%0d.status", i), int'(bus.end_status), int'(vecs[i].st));
        end
        bus.shoot   = 1'b0;
        bus.is_won  = 1'b0;
        bus.is_lost = 1'b0;
        bus.score   = 8'd0;
        m_score     = 0;
        do_reset("reset2");

        // Full game to victory, with score saturation and a held shoot in WON
        press();
        play_score(12);
        outcome(1'b1, 1'b0);
        do_hold();
        play_score(78);
        outcome(1'b1, 1'b0);
        do_hold();
        play_score(15);
        bus.shoot = 1'b1;
        step();
        check_all("shoot_in_play");
        outcome(1'b1, 1'b0);
        repeat (3) step();
        check_all("won_held");
        bus.shoot = 1'b0;
        step();
        check_all("won_released");
        press_end();

        // Simultaneous win and loss until the game is lost
        press();
        for (int k = 0; k < 10 && m_phase != PhLost; k++) begin
            if (m_phase == PhRetry) do_hold();
            else begin
                play_score(20 + k);
                outcome(1'b1, 1'b1);
            end
        end
        chk("both_flags_lost", m_phase, PhLost);
        press_end();

        // Reset in the middle of play
        press();
        play_score(33);
        step();
        do_reset("reset_mid_play");

        // Randomized games
        for (int g = 0; g < 4; g++) begin
            press();
            for (int k = 0; k < 20 && m_phase != PhWon && m_phase != PhLost; k++) begin
                if (m_phase == PhCleared || m_phase == PhRetry) begin
                    do_hold();
                end else begin
                    int r;
                    play_score(int'($urandom_range(0, 60)));
                    r = int'($urandom_range(0, 9));
                    outcome(r <= 5, r >= 5);
                end
            end
            press_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller for the space invaders top level. It sequences the level datapaths: title screen, level load, play, inter-level hold, retry, game over and victory. It drives the level select, the colour-mapper select and the level reset, and keeps the cumulative score shown on HEX0/HEX1. It sits between the per-level instances (which report win, loss and score) and the top-level VGA mux.

## Interface
Parameters:
- NUM_LEVELS, 3, number of playable levels (1–3).
- HOLD_FRAMES, 120, frame ticks spent in CLEARED/RETRY before next LOAD (≥1).
- LIVES, 3, lives at game start (used only with LEVEL_SEQ_LIVES_EN).
- SCORE_MAX, 99, saturation value of display_score.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  VGA_VS, asynchronous to game logic semantics; rising edge = frame tick.
- shoot  in  1  registered fire/start request (KEY3 or keycode 44).
- is_won  in  1  win flag of the selected level.
- is_lost  in  1  loss flag of the selected level.
- score  in  8  unsigned score of the selected level.
- level  out  2  index of the active level, 0..NUM_LEVELS-1.
- color_mapper_select  out  2  0..2 = level mapper, 3 = end/title mapper.
- level_reset  out  1  hold level datapaths in reset.
- end_status  out  2  0 TITLE, 1 CLEARED/RETRY, 2 WON, 3 LOST (meaningful when select = 3).
- display_score  out  8  banked + live score, saturated at SCORE_MAX.
- lives_left  out  2  remaining lives (constant LIVES without the macro).

## Operation
- Frame tick: 2-flop synchroniser on frame_clk, then rising-edge detect → 1-cycle tick pulse.
- Start edge: shoot_rise = shoot & ~shoot_q. Only rising edges advance states. A held shoot never retriggers.
- States and transitions:
  - TITLE: select 3, status 0. shoot_rise → LOAD; level←0, banked←0, lives←LIVES.
  - LOAD: exactly 1 cycle, then → PLAY. hold_cnt←0.
  - PLAY: select = level, level_reset 0. Flags are ignored in the first PLAY cycle.
    - is_lost (takes priority when both flags are set): lives>1 → lives−1, → RETRY; otherwise → LOST.
    - is_won: banked←sat(banked+score). If level = NUM_LEVELS−1 → WON, else → CLEARED.
  - CLEARED: select 3, status 1. hold_cnt counts ticks. At HOLD_FRAMES: level←level+1, → LOAD.
  - RETRY: same hold as CLEARED. Level is unchanged and its live score is discarded. → LOAD.
  - WON: status 2. LOST: status 3. In both, select 3 and shoot_rise → TITLE.
- level_reset = 1 in every state except PLAY.
- display_score = sat(banked + score) in PLAY, banked otherwise. Use a 9-bit intermediate sum, clamped to SCORE_MAX.
- Reset, at any point: state TITLE, level 0, select 3, level_reset 1, end_status 0, display_score 0, lives_left LIVES, hold_cnt 0, synchroniser and edge registers 0.

## Timing
- All outputs are registered; they change 1 cycle after the causing input or state change.
- shoot_rise in TITLE:
  - cycle N+1 LOAD, level_reset 1, select 3;
  - cycle N+2 PLAY, level_reset 0, select = level.
- Win/loss: flag sampled at cycle N → new state and banked score at N+1. Flags in CLEARED/RETRY/WON/LOST/TITLE are ignored.
- Hold duration: exactly HOLD_FRAMES tick pulses after entering CLEARED/RETRY. LOAD follows 1 cycle after the final tick.
- A tick and shoot_rise in the same cycle are handled independently. Hold states ignore shoot.

## Configuration
- LEVEL_SEQ_LIVES_EN defined: lives counter and RETRY state are present. A loss with lives>1 replays the same level.
- Not defined: no lives register and no RETRY state. Any loss goes to LOST; lives_left is tied to LIVES.

## Structure
- Package game_pkg: state enum (TITLE, LOAD, PLAY, CLEARED, RETRY, WON, LOST), end_status encodings, MAPPER_END = 2'd3.
- One sub-module, frame_tick_gen: synchroniser plus edge detect for frame_clk. It is reusable by level datapaths.
- The remainder is a single FSM with the hold counter and score/lives registers.

## Test plan
- Reset, then shoot pulse → LOAD for 1 cycle with level_reset 1, then PLAY with level 0, select 0, level_reset 0.
- In level 0, score 12 then is_won → display_score 12, CLEARED status 1, select 3. After 120 ticks → LOAD, then PLAY with level 1.
- Banked 90, level score 15, is_won → display_score saturates at 99.
- is_won and is_lost asserted in the same cycle, lives 1 → LOST, status 3, banked score unchanged.
- With LEVEL_SEQ_LIVES_EN:
  - loss at lives 3 → RETRY, lives_left 2, same level reloaded after 120 ticks, display_score = banked only;
  - loss at lives 1 → LOST.
- Win on level 2 → WON. Shoot held high → stays in WON. Release then press → TITLE. Reset asserted mid-PLAY → TITLE next cycle with all outputs at their reset values.
